// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Signal bundle between the clock's time counters and the 7-segment scanner.
//
// Signals:
//   hours_bin   [4:0]  binary hours 0..23 from the time counters
//   minutes_bin [5:0]  binary minutes 0..59 from the time counters
//   sec_tick           one-cycle pulse per second (colon blink only)
//   seg         [6:0]  segment pins {g,f,e,d,c,b,a}
//   dp                 decimal point pin, used as the HH:MM colon
//   dig_sel     [3:0]  one-hot digit select pins, bit0 = leftmost digit
//
// Modports:
//   master  time source / display side (drives time, observes pins)
//   slave   the scan driver (consumes time, drives pins)
//
// Handshake: there is no valid/ready pair. hours_bin/minutes_bin are plain
// levels that the driver samples once at the start of every scan frame;
// sec_tick is a single-cycle strobe acted on in the cycle it is high.
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
   logic [4:0] hours_bin;
   logic [5:0] minutes_bin;
   logic       sec_tick;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] dig_sel;

   modport master (
      output hours_bin,
      output minutes_bin,
      output sec_tick,
      input  seg,
      input  dp,
      input  dig_sel
   );

   modport slave (
      input  hours_bin,
      input  minutes_bin,
      input  sec_tick,
      output seg,
      output dp,
      output dig_sel
   );
endinterface

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Drives a 4-digit multiplexed 7-segment display as HH.MM. Hours/minutes are
// captured once per scan frame into a shadow register, split into decimal
// digits, encoded to segments and scanned with a blank dead time at the start
// of every digit slot to suppress ghosting.
//
// Ports:
//   sys_clk     system clock
//   sys_rst_n   synchronous active-low reset
//   bus         seg_scan_driver_if.slave: hours_bin, minutes_bin, sec_tick in;
//               seg, dp, dig_sel out (all outputs registered)
//
// Parameters:
//   CLK_HZ, SCAN_HZ   slot length DIV = CLK_HZ/SCAN_HZ cycles
//   BLANK_CYCLES      dead-time cycles at the start of each slot (1..DIV-1)
//   SEG_ACTIVE_LOW    1 inverts seg and dp at the pins
//   SEL_ACTIVE_LOW    1 inverts dig_sel at the pins
//
// Optional feature macro: SEG_SCAN_DRIVER_COLON_BLINK_EN
//   defined   : colon toggles on every sec_tick pulse
//   undefined : colon steadily on, sec_tick ignored
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int CLK_HZ         = 27000000,
   parameter int SCAN_HZ        = 1000,
   parameter int BLANK_CYCLES   = 27,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int SEL_ACTIVE_LOW = 0
) (
   input logic             sys_clk,
   input logic             sys_rst_n,
   seg_scan_driver_if.slave bus
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   // Pin-level "inactive" values, i.e. after polarity inversion.
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [3:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   localparam logic [6:0] SEG_DASH = 7'h40;

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   function automatic logic [6:0] seg_encode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Tens digit by comparison; only meaningful for v < 60, larger values are
   // caught by the validity check and shown as dashes.
   function automatic logic [3:0] tens_of(input logic [5:0] v);
      logic [3:0] t;
      if      (v >= 6'd50) t = 4'd5;
      else if (v >= 6'd40) t = 4'd4;
      else if (v >= 6'd30) t = 4'd3;
      else if (v >= 6'd20) t = 4'd2;
      else if (v >= 6'd10) t = 4'd1;
      else                 t = 4'd0;
      return t;
   endfunction

   function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [3:0] t);
      return 4'(v - 6'({2'b00, t} * 6'd10));
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] slot_cnt_q,  slot_cnt_d;
   logic [1:0]       digit_idx_q, digit_idx_d;
   logic [4:0]       hours_q,     hours_d;
   logic [5:0]       minutes_q,   minutes_d;
   logic [6:0]       seg_q,       seg_d;
   logic             dp_q,        dp_d;
   logic [3:0]       dig_sel_q,   dig_sel_d;

   logic             colon_on;

`ifdef SEG_SCAN_DRIVER_COLON_BLINK_EN
   logic blink_q, blink_d;

   always_comb begin
      blink_d = blink_q;
      if (bus.sec_tick) blink_d = ~blink_q;
   end

   // Reset has priority, so a sec_tick coincident with reset is dropped.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) blink_q <= 1'b1;
      else            blink_q <= blink_d;
   end

   assign colon_on = blink_q;
`else
   logic unused_sec_tick;
   assign unused_sec_tick = bus.sec_tick;
   assign colon_on        = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------
   logic       slot_wrap;
   logic       frame_start;
   logic       show;
   logic       shadow_valid;
   logic [3:0] h_tens, h_ones, m_tens, m_ones;
   logic [3:0] digit_val;
   logic [6:0] seg_raw;
   logic       dp_raw;
   logic [3:0] sel_raw;

   always_comb begin
      slot_wrap    = (slot_cnt_q == LAST_SLOT);
      frame_start  = (slot_cnt_q == '0) && (digit_idx_q == 2'd0);
      show         = (slot_cnt_q >= BLANK_END);
      shadow_valid = (hours_q <= 5'd23) && (minutes_q <= 6'd59);

      slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
      // 2-bit index wraps 3 -> 0 on its own.
      digit_idx_d = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

      // Shadow only moves at the frame boundary. That cycle is always in a
      // BLANK phase, so the display never shows a half-updated frame.
      hours_d   = frame_start ? bus.hours_bin   : hours_q;
      minutes_d = frame_start ? bus.minutes_bin : minutes_q;

      h_tens = tens_of({1'b0, hours_q});
      h_ones = ones_of({1'b0, hours_q}, h_tens);
      m_tens = tens_of(minutes_q);
      m_ones = ones_of(minutes_q, m_tens);

      case (digit_idx_q)
         2'd0:    digit_val = h_tens;
         2'd1:    digit_val = h_ones;
         2'd2:    digit_val = m_tens;
         default: digit_val = m_ones;
      endcase

      seg_raw = 7'h00;
      dp_raw  = 1'b0;
      sel_raw = 4'h0;
      if (show) begin
         sel_raw[digit_idx_q] = 1'b1;
         if (!shadow_valid) begin
            seg_raw = SEG_DASH;
         end else begin
            // Leading-zero blank on the hours tens digit.
            if (digit_idx_q == 2'd0 && digit_val == 4'd0) seg_raw = 7'h00;
            else                                          seg_raw = seg_encode(digit_val);
            dp_raw = (digit_idx_q == 2'd1) && colon_on;
         end
      end

      // Polarity applied right before the output flops.
      seg_d     = seg_raw ^ SEG_OFF;
      dp_d      = dp_raw  ^ DP_OFF;
      dig_sel_d = sel_raw ^ SEL_OFF;
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         slot_cnt_q  <= '0;
         digit_idx_q <= 2'd0;
         hours_q     <= 5'd0;
         minutes_q   <= 6'd0;
         seg_q       <= SEG_OFF;
         dp_q        <= DP_OFF;
         dig_sel_q   <= SEL_OFF;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         digit_idx_q <= digit_idx_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         dig_sel_q   <= dig_sel_d;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.dp      = dp_q;
   assign bus.dig_sel = dig_sel_q;

endmodule
